// File: rtl/wav_dfi_lp_requester_pkg.sv
// Shared types and default timing for the DFI low-power requester.
//
// Contents:
//   lp_state_e        handshake FSM states
//   DEF_TLP_RESP      default cycles lp_req may wait for ack before it is withdrawn
//   DEF_TEXIT_MAX     default cycles allowed for ack to fall after lp_req falls
//   DEF_MIN_IDLE      default minimum low cycles between two lp_req assertions
//   DEF_WAKEUP_W      default width of the wakeup code
//   max_int()         elaboration-time helper for sizing counters
package wav_DFI_lp_pkg;

  localparam int DEF_TLP_RESP  = 8;
  localparam int DEF_TEXIT_MAX = 32;
  localparam int DEF_MIN_IDLE  = 2;
  localparam int DEF_WAKEUP_W  = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    GRANT = 3'd2,
    EXIT  = 3'd3,
    BLOCK = 3'd4
  } lp_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wav_dfi_lp_requester_timer.sv
// Clearable saturating up-counter with a terminal-count flag.
//
// Ports:
//   clock    in   clock
//   reset    in   synchronous active-high reset, loads RESET_VAL
//   clear    in   synchronous clear to zero (wins over enable)
//   enable   in   count up by one, holding at SAT
//   tc       out  high while the count equals TC
module wav_dfi_lp_timer #(
  parameter int WIDTH     = 6,
  parameter int SAT       = 8,
  parameter int TC        = 7,
  parameter int RESET_VAL = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [WIDTH-1:0] SAT_V = WIDTH'(SAT);
  localparam logic [WIDTH-1:0] TC_V  = WIDTH'(TC);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count;

  // Count register: reset preloads, clear restarts from zero, and the
  // count parks at SAT so a long wait never wraps back into the TC window.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= RST_V;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT_V)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_V);

endmodule

// File: rtl/wav_dfi_lp_requester.sv
// MC-side DFI low-power handshake master for one channel (lp_ctrl or lp_data).
// Turns a level host request into lp_req/lp_wakeup, follows lp_ack, withdraws
// an unanswered request after TLP_RESP cycles and flags a slow ack release.
//
// Ports:
//   clock        in   DFI clock
//   reset        in   synchronous active-high reset
//   host_lp_en   in   1 = enter/hold low power, 0 = exit
//   host_wakeup  in   wakeup code, captured when lp_req rises
//   lp_ack       in   lp_*_ack from the PHY
//   lp_req       out  lp_*_req
//   lp_wakeup    out  lp_*_wakeup, held constant while lp_req is high
//   lp_granted   out  PHY has acknowledged, low power active
//   lp_timeout   out  one-cycle pulse: no ack within TLP_RESP cycles
//   lp_exit_err  out  one-cycle pulse: ack late to fall, or dropped early
//   busy         out  handshake FSM not idle
module wav_dfi_lp_requester
  import wav_DFI_lp_pkg::*;
#(
  parameter int TLP_RESP  = DEF_TLP_RESP,
  parameter int TEXIT_MAX = DEF_TEXIT_MAX,
  parameter int MIN_IDLE  = DEF_MIN_IDLE,
  parameter int WAKEUP_W  = DEF_WAKEUP_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                host_lp_en,
  input  logic [WAKEUP_W-1:0] host_wakeup,
  input  logic                lp_ack,
  output logic                lp_req,
  output logic [WAKEUP_W-1:0] lp_wakeup,
  output logic                lp_granted,
  output logic                lp_timeout,
  output logic                lp_exit_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(max_int(max_int(TLP_RESP, TEXIT_MAX), MIN_IDLE) + 1);

  lp_state_e           state_q;
  lp_state_e           state_d;
  logic                lp_req_d;
  logic [WAKEUP_W-1:0] lp_wakeup_d;
  logic                lp_granted_d;
  logic                lp_timeout_d;
  logic                lp_exit_err_d;

  logic resp_clr;
  logic resp_en;
  logic resp_last;
  logic exit_clr;
  logic exit_en;
  logic exit_last;
  logic idle_clr;
  logic idle_ok;

  // Response window: tc marks the last cycle the request may stay unanswered.
  wav_dfi_lp_timer #(
    .WIDTH(CNT_W), .SAT(TLP_RESP), .TC(TLP_RESP - 1), .RESET_VAL(0)
  ) u_resp_timer (
    .clock(clock), .reset(reset), .clear(resp_clr), .enable(resp_en), .tc(resp_last)
  );

  // Exit window: tc is true for exactly one EXIT cycle because the count
  // moves past TC to saturate at TEXIT_MAX, giving a single error pulse.
  wav_dfi_lp_timer #(
    .WIDTH(CNT_W), .SAT(TEXIT_MAX), .TC(TEXIT_MAX - 1), .RESET_VAL(0)
  ) u_exit_timer (
    .clock(clock), .reset(reset), .clear(exit_clr), .enable(exit_en), .tc(exit_last)
  );

  // Idle spacing: saturates at MIN_IDLE so tc reads as "enough low cycles".
  // Preloaded on reset so the first request after reset may start at once.
  wav_dfi_lp_timer #(
    .WIDTH(CNT_W), .SAT(MIN_IDLE), .TC(MIN_IDLE), .RESET_VAL(MIN_IDLE)
  ) u_idle_timer (
    .clock(clock), .reset(reset), .clear(idle_clr), .enable(!lp_req), .tc(idle_ok)
  );

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so the DFI pins never see combinational glitches.
  // In REQ an arriving ack beats both the host dropping out and the
  // response timeout; a host drop withdraws quietly without a timeout pulse.
  // In GRANT an ack that vanishes while we still request is an error.
  always_comb begin
    state_d       = state_q;
    lp_req_d      = lp_req;
    lp_wakeup_d   = lp_wakeup;
    lp_granted_d  = lp_granted;
    lp_timeout_d  = 1'b0;
    lp_exit_err_d = 1'b0;
    resp_clr      = 1'b0;
    resp_en       = 1'b0;
    exit_clr      = 1'b0;
    exit_en       = 1'b0;
    idle_clr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (host_lp_en && idle_ok && !lp_ack) begin
          state_d     = REQ;
          lp_req_d    = 1'b1;
          lp_wakeup_d = host_wakeup;
          resp_clr    = 1'b1;
        end
      end

      REQ: begin
        if (lp_ack) begin
          state_d      = GRANT;
          lp_granted_d = 1'b1;
        end else if (!host_lp_en) begin
          state_d  = EXIT;
          lp_req_d = 1'b0;
          exit_clr = 1'b1;
        end else if (resp_last) begin
          state_d      = BLOCK;
          lp_req_d     = 1'b0;
          lp_timeout_d = 1'b1;
        end else begin
          resp_en = 1'b1;
        end
      end

      GRANT: begin
        if (!lp_ack) begin
          state_d       = EXIT;
          lp_req_d      = 1'b0;
          lp_granted_d  = 1'b0;
          lp_exit_err_d = 1'b1;
          exit_clr      = 1'b1;
        end else if (!host_lp_en) begin
          state_d      = EXIT;
          lp_req_d     = 1'b0;
          lp_granted_d = 1'b0;
          exit_clr     = 1'b1;
        end
      end

      EXIT: begin
        if (!lp_ack) begin
          state_d  = IDLE;
          idle_clr = 1'b1;
        end else begin
          exit_en       = 1'b1;
          lp_exit_err_d = exit_last;
        end
      end

      BLOCK: begin
        if (!host_lp_en) begin
          state_d  = IDLE;
          idle_clr = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops every DFI output on the next
  // edge, even mid-handshake; the IDLE ack guard then holds off a new
  // request until the PHY releases its ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      lp_req      <= 1'b0;
      lp_wakeup   <= '0;
      lp_granted  <= 1'b0;
      lp_timeout  <= 1'b0;
      lp_exit_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lp_req      <= lp_req_d;
      lp_wakeup   <= lp_wakeup_d;
      lp_granted  <= lp_granted_d;
      lp_timeout  <= lp_timeout_d;
      lp_exit_err <= lp_exit_err_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_wav_dfi_lp_requester.sv
// Directed bench for wav_dfi_lp_requester: a per-cycle vector table for
// entry, exit and spurious-ack behaviour, then hand sequences for timeout,
// the ack/timeout race, the exit error window and reset mid-grant.
module tb_wav_dfi_lp_requester;

  logic       clock = 1'b0;
  logic       reset;
  logic       host_lp_en;
  logic [5:0] host_wakeup;
  logic       lp_ack;
  logic       lp_req;
  logic [5:0] lp_wakeup;
  logic       lp_granted;
  logic       lp_timeout;
  logic       lp_exit_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int tout_seen = 0;
  int err_seen = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [5:0] wk;
    logic       ack;
    logic [10:0] expv;
  } vec_t;

  vec_t vecs[17];

  wav_dfi_lp_requester dut (
    .clock(clock),
    .reset(reset),
    .host_lp_en(host_lp_en),
    .host_wakeup(host_wakeup),
    .lp_ack(lp_ack),
    .lp_req(lp_req),
    .lp_wakeup(lp_wakeup),
    .lp_granted(lp_granted),
    .lp_timeout(lp_timeout),
    .lp_exit_err(lp_exit_err),
    .busy(busy)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // Hard stop in case a sequence never reaches its end.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Protocol monitor sampled on the falling edge: timeout and exit error
  // never together, lp_req never rises onto a held ack, and lp_wakeup
  // stays fixed while lp_req is held high.
  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic [5:0] prev_wk  = '0;
  always @(negedge clock) begin
    checks++;
    if (lp_timeout === 1'b1 && lp_exit_err === 1'b1) begin
      errors++;
      $display("[TB] FAIL mon_exclusive at %0t: timeout=1 exit_err=1, required not both", $time);
    end
    checks++;
    if (reset !== 1'b1 && lp_req === 1'b1 && prev_req === 1'b0 && prev_ack === 1'b1) begin
      errors++;
      $display("[TB] FAIL mon_req_on_ack at %0t: req rose with ack=1, required req=0", $time);
    end
    checks++;
    if (lp_req === 1'b1 && prev_req === 1'b1 && lp_wakeup !== prev_wk) begin
      errors++;
      $display("[TB] FAIL mon_wakeup_stable at %0t: wakeup=%h, required %h", $time, lp_wakeup, prev_wk);
    end
    prev_req = lp_req;
    prev_ack = lp_ack;
    prev_wk  = lp_wakeup;
  end

  function automatic vec_t mk(input logic r, input logic e, input logic [5:0] w, input logic a,
                              input logic q, input logic [5:0] qw, input logic g,
                              input logic t, input logic x, input logic b);
    vec_t v;
    v.rst  = r;
    v.en   = e;
    v.wk   = w;
    v.ack  = a;
    v.expv = {q, qw, g, t, x, b};
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic e, input logic [5:0] w, input logic a);
    reset       = r;
    host_lp_en  = e;
    host_wakeup = w;
    lp_ack      = a;
  endtask

  // One clock edge, then sample 1 unit later; pulses are tallied here.
  task automatic tick();
    @(posedge clock);
    #1;
    if (lp_timeout === 1'b1) tout_seen++;
    if (lp_exit_err === 1'b1) err_seen++;
  endtask

  task automatic checkOutput(input string name, input logic [10:0] expv);
    logic [10:0] act;
    act = {lp_req, lp_wakeup, lp_granted, lp_timeout, lp_exit_err, busy};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: {req,wk,gr,to,err,busy} got %b_%h_%b%b%b%b, required %b_%h_%b%b%b%b",
               name, act[10], act[9:4], act[3], act[2], act[1], act[0],
               expv[10], expv[9:4], expv[3], expv[2], expv[1], expv[0]);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  initial begin
    int hi;
    int err_at;

    // rst en wk ack | req wk gr to err busy
    vecs[0]  = mk(1, 0, 6'h00, 0,  0, 6'h00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 6'h05, 0,  1, 6'h05, 0, 0, 0, 1);
    vecs[2]  = mk(0, 1, 6'h05, 0,  1, 6'h05, 0, 0, 0, 1);
    vecs[3]  = mk(0, 1, 6'h05, 0,  1, 6'h05, 0, 0, 0, 1);
    vecs[4]  = mk(0, 1, 6'h05, 1,  1, 6'h05, 1, 0, 0, 1);
    vecs[5]  = mk(0, 1, 6'h2A, 1,  1, 6'h05, 1, 0, 0, 1);
    vecs[6]  = mk(0, 0, 6'h2A, 1,  0, 6'h05, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 6'h2A, 1,  0, 6'h05, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 6'h2A, 1,  0, 6'h05, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 6'h2A, 1,  0, 6'h05, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 6'h2A, 0,  0, 6'h05, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 6'h11, 0,  0, 6'h05, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 6'h11, 0,  0, 6'h05, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 6'h11, 0,  1, 6'h11, 0, 0, 0, 1);
    vecs[14] = mk(0, 1, 6'h11, 1,  1, 6'h11, 1, 0, 0, 1);
    vecs[15] = mk(0, 1, 6'h11, 0,  0, 6'h11, 0, 0, 1, 1);
    vecs[16] = mk(0, 1, 6'h11, 0,  0, 6'h11, 0, 0, 0, 0);

    applyStimulus(1, 0, 6'h00, 0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].wk, vecs[i].ack);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].expv);
    end

    // Timeout: request never acked, host keeps asking.
    tout_seen = 0;
    hi = 0;
    applyStimulus(0, 1, 6'h09, 0);
    for (int k = 0; k < 25; k++) begin
      tick();
      if (lp_req === 1'b1) hi++;
    end
    checkValue("timeout_req_high_cycles", hi, 8);
    checkValue("timeout_pulse_count", tout_seen, 1);
    checkValue("block_busy", int'(busy), 1);
    checkValue("block_req_low", int'(lp_req), 0);
    applyStimulus(0, 0, 6'h09, 0);
    tick();
    checkValue("block_release_busy", int'(busy), 0);

    // Race: ack lands on the last allowed response cycle.
    applyStimulus(0, 0, 6'h3C, 0);
    repeat (3) tick();
    tout_seen = 0;
    applyStimulus(0, 1, 6'h3C, 0);
    tick();
    checkValue("race_req_rise", int'(lp_req), 1);
    repeat (7) tick();
    applyStimulus(0, 1, 6'h3C, 1);
    tick();
    checkOutput("race_ack_wins", {1'b1, 6'h3C, 1'b1, 1'b0, 1'b0, 1'b1});
    applyStimulus(0, 1, 6'h07, 1);
    tick();
    checkOutput("granted_wakeup_hold", {1'b1, 6'h3C, 1'b1, 1'b0, 1'b0, 1'b1});
    checkValue("race_no_timeout", tout_seen, 0);

    // Exit error: ack held 40 cycles after lp_req falls.
    applyStimulus(0, 0, 6'h07, 1);
    tick();
    checkOutput("exit_req_fall", {1'b0, 6'h3C, 1'b0, 1'b0, 1'b0, 1'b1});
    err_seen = 0;
    err_at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (lp_exit_err === 1'b1) err_at = k;
    end
    checkValue("exit_err_count", err_seen, 1);
    checkValue("exit_err_cycle", err_at, 32);
    checkValue("exit_wait_busy", int'(busy), 1);
    applyStimulus(0, 0, 6'h07, 0);
    tick();
    checkValue("exit_done_busy", int'(busy), 0);

    // Reset while granted with the PHY still acking.
    repeat (3) tick();
    applyStimulus(0, 1, 6'h15, 0);
    tick();
    applyStimulus(0, 1, 6'h15, 1);
    tick();
    checkValue("pre_reset_granted", int'(lp_granted), 1);
    applyStimulus(1, 1, 6'h15, 1);
    tick();
    checkOutput("reset_in_grant", 11'b0);
    applyStimulus(0, 1, 6'h15, 1);
    hi = 0;
    repeat (4) begin
      tick();
      if (lp_req === 1'b1) hi++;
    end
    checkValue("no_req_while_ack", hi, 0);
    applyStimulus(0, 1, 6'h15, 0);
    tick();
    checkOutput("req_after_ack_low", {1'b1, 6'h15, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
